// File: rtl/fmap_pingpong_buffer.sv
// fmap_pingpong_buffer: two-bank feature-map buffer. A producer fills one
// bank while a consumer reads the other. Ownership of each bank moves between
// the two sides through done/ready handshakes. Reads have one cycle of latency.
module fmap_pingpong_buffer #(
  parameter int DEPTH   = 112*112,
  parameter int BITSIZE = 14,
  parameter int IDX_W   = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_index,
  input  logic signed [BITSIZE-1:0] wr_data,
  input  logic                      wr_done,
  output logic                      wr_ready,
  input  logic                      rd_en,
  input  logic [IDX_W-1:0]          rd_index,
  input  logic                      rd_done,
  output logic                      rd_ready,
  output logic signed [BITSIZE-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      oor_err
);

  // Address width of one bank. Indices are range-checked before this slice
  // is used, so an out-of-range index can never alias onto a valid pixel.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);

  logic [1:0]         full_reg, full_next;
  logic               wr_sel_reg, rd_sel_reg;
  logic               rd_bank_reg;   // bank whose read register drives rd_data
  logic               rd_zero_reg;   // rd_data forced to 0 (after reset or OOR read)
  logic               rd_valid_reg;
  logic               oor_reg;
  logic [BITSIZE-1:0] bank_q [2];    // registered read word of each bank

  logic wr_in_range, rd_in_range;
  logic wr_acc, wr_write, wr_close;
  logic rd_acc, rd_close;
  logic [AW-1:0] wr_addr, rd_addr;

  assign wr_ready = !full_reg[wr_sel_reg];
  assign rd_ready =  full_reg[rd_sel_reg];

  assign wr_in_range = {1'b0, wr_index} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_index} < DEPTH_W;
  assign wr_addr     = wr_index[AW-1:0];
  assign rd_addr     = rd_index[AW-1:0];

  assign wr_acc   = wr_en   && wr_ready;
  assign wr_write = wr_acc  && wr_in_range;
  assign wr_close = wr_done && wr_ready;
  assign rd_acc   = rd_en   && rd_ready;
  assign rd_close = rd_done && rd_ready;

  // Next bank-full flags. An accepted close and an accepted release always
  // target different banks, so both updates can be applied in one cycle.
  always_comb begin
    full_next = full_reg;
    if (wr_close) full_next[wr_sel_reg] = 1'b1;
    if (rd_close) full_next[rd_sel_reg] = 1'b0;
  end

  // Per-bank storage. The write uses the current write pointer, so a write
  // issued together with wr_done lands in the bank being closed. The read
  // likewise uses the bank being released when rd_en and rd_done coincide.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [BITSIZE-1:0] mem [DEPTH];

    // Memory write port.
    always_ff @(posedge clk) begin
      if (wr_write && (wr_sel_reg == 1'(gi))) mem[wr_addr] <= wr_data;
    end

    // Registered memory read port.
    always_ff @(posedge clk) begin
      if (rd_acc && rd_in_range && (rd_sel_reg == 1'(gi))) bank_q[gi] <= mem[rd_addr];
    end
  end

  // Output word: the read register of the last bank read, or zero after
  // reset or an out-of-range read. It holds while no read is accepted.
  assign rd_data  = rd_zero_reg ? '0 : $signed(bank_q[rd_bank_reg]);
  assign rd_valid = rd_valid_reg;
  assign oor_err  = oor_reg;

  // Ownership pointers, flags, read tracking and the sticky range error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_reg     <= 2'b00;
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      rd_bank_reg  <= 1'b0;
      rd_zero_reg  <= 1'b1;
      rd_valid_reg <= 1'b0;
      oor_reg      <= 1'b0;
    end else begin
      full_reg     <= full_next;
      rd_valid_reg <= rd_acc;
      if (wr_close) wr_sel_reg <= !wr_sel_reg;
      if (rd_close) rd_sel_reg <= !rd_sel_reg;
      if (rd_acc) begin
        rd_bank_reg <= rd_sel_reg;
        rd_zero_reg <= !rd_in_range;
      end
      if ((wr_acc && !wr_in_range) || (rd_acc && !rd_in_range)) oor_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// tb_fmap_pingpong_buffer: directed scoreboard bench for the ping-pong buffer
// (DEPTH=16). Reads push their expected pixel; a monitor pops on rd_valid.
module tb_fmap_pingpong_buffer;

  localparam int DEPTH   = 16;
  localparam int BITSIZE = 14;
  localparam int IDX_W   = 14;

  logic                      clk;
  logic                      rst;
  logic                      wr_en;
  logic [IDX_W-1:0]          wr_index;
  logic signed [BITSIZE-1:0] wr_data;
  logic                      wr_done;
  logic                      wr_ready;
  logic                      rd_en;
  logic [IDX_W-1:0]          rd_index;
  logic                      rd_done;
  logic                      rd_ready;
  logic signed [BITSIZE-1:0] rd_data;
  logic                      rd_valid;
  logic                      oor_err;

  int checks   = 0;
  int failures = 0;
  logic [BITSIZE-1:0] exp_q [$];

  fmap_pingpong_buffer #(.DEPTH(DEPTH), .BITSIZE(BITSIZE), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .wr_done(wr_done),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_index(rd_index), .rd_done(rd_done), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .oor_err(oor_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got rd_valid=1 data=%0d required no read", rd_data);
      end else begin
        logic [BITSIZE-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL rd_data got %0d required %0d", rd_data, $signed(e));
        end else begin
          $display("read ok data=%0d", rd_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end else begin
      $display("check %s = %0h", name, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus on both ports; exp_rd says whether the read
  // should be accepted and what it must return.
  task automatic step(input bit we, input int wi, input int wd, input bit wdn,
                      input bit re, input int ri, input bit rdn,
                      input bit exp_rd, input int rexp);
    wr_en    = we;
    wr_index = IDX_W'(wi);
    wr_data  = BITSIZE'(wd);
    wr_done  = wdn;
    rd_en    = re;
    rd_index = IDX_W'(ri);
    rd_done  = rdn;
    if (exp_rd) exp_q.push_back(BITSIZE'(rexp));
    cyc();
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; wr_index = '0; wr_data = '0; wr_done = 1'b0;
    rd_en = 1'b0; rd_index = '0; rd_done = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (2) cyc();

    // Reset / idle state.
    chk("reset_wr_ready", 32'(wr_ready), 1);
    chk("reset_rd_ready", 32'(rd_ready), 0);
    chk("reset_rd_data",  32'(rd_data),  0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_oor_err",  32'(oor_err),  0);

    // Fill bank 0 with i-8192, then close it.
    for (int i = 0; i < DEPTH; i++) step(1, i, i - 8192, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("fill0_rd_ready", 32'(rd_ready), 1);
    chk("fill0_wr_ready", 32'(wr_ready), 1);
    step(0, 0, 0, 0, 1, 5, 0, 1, -8187);
    step(0, 0, 0, 0, 1, 0, 0, 1, -8192);
    step(0, 0, 0, 0, 1, 15, 0, 1, -8177);

    // Fill bank 1 with 0x1FFF while reading bank 0; index 15 written with wr_done.
    for (int i = 0; i < DEPTH - 1; i++)
      step(1, i, 14'h1FFF, 0, 1, i, 0, 1, i - 8192);
    step(1, 15, 14'h0123, 1, 0, 0, 0, 0, 0);
    chk("both_full_wr_ready", 32'(wr_ready), 0);
    chk("both_full_rd_ready", 32'(rd_ready), 1);

    // Blocked write and close while both banks are full.
    step(1, 0, 14'h0555, 1, 0, 0, 0, 0, 0);
    chk("blocked_wr_ready", 32'(wr_ready), 0);
    chk("blocked_rd_ready", 32'(rd_ready), 1);

    // Read and release together: data comes from the released bank 0.
    step(0, 0, 0, 0, 1, 3, 1, 1, -8189);
    chk("release0_wr_ready", 32'(wr_ready), 1);
    chk("release0_rd_ready", 32'(rd_ready), 1);
    step(0, 0, 0, 0, 1, 0, 0, 1, 14'h1FFF);
    step(0, 0, 0, 0, 1, 15, 0, 1, 14'h0123);
    step(0, 0, 0, 0, 1, 7, 0, 1, 14'h1FFF);

    // Partially refill bank 0 (index 0 untouched), then close and release together.
    for (int i = 1; i <= 4; i++) step(1, i, 100 + i, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0, 0);
    chk("simul_wr_ready", 32'(wr_ready), 1);
    chk("simul_rd_ready", 32'(rd_ready), 1);
    step(0, 0, 0, 0, 1, 0, 0, 1, -8192);
    step(0, 0, 0, 0, 1, 2, 0, 1, 102);

    // Release bank 0: nothing readable, a read must be ignored.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("empty_rd_ready", 32'(rd_ready), 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("blocked_rd_valid", 32'(rd_valid), 0);

    // Out-of-range write into bank 1, then close it and read.
    step(1, 16, 14'h0AAA, 0, 0, 0, 0, 0, 0);
    chk("oor_write_err", 32'(oor_err), 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 20, 0, 1, 0);
    chk("oor_read_valid", 32'(rd_valid), 1);
    chk("oor_read_data",  32'(rd_data),  0);
    step(0, 0, 0, 0, 1, 0, 0, 1, 14'h1FFF);
    cyc();

    // Asynchronous mid-run reset.
    rst = 1'b0;
    #2;
    chk("midrst_oor_err",  32'(oor_err),  0);
    chk("midrst_rd_ready", 32'(rd_ready), 0);
    chk("midrst_wr_ready", 32'(wr_ready), 1);
    chk("midrst_rd_valid", 32'(rd_valid), 0);
    chk("midrst_rd_data",  32'(rd_data),  0);
    cyc();
    rst = 1'b1;
    repeat (2) cyc();

    chk("pending_reads", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
